// File: rtl/wash_cycle_sequencer.sv
// Washing-machine program sequencer: fill, wash, rinse (with optional second wash and extra
// rinses), spin, plus pause and an abort path that forces a drain phase.
module wash_cycle_sequencer #(
   parameter int unsigned CNT_W       = 32,
   parameter int unsigned FILL_TICKS  = 120000000,
   parameter int unsigned WASH_TICKS  = 300000000,
   parameter int unsigned RINSE_TICKS = 120000000,
   parameter int unsigned SPIN_TICKS  = 60000000,
   parameter int unsigned DRAIN_TICKS = 30000000,
   parameter int unsigned ER_W        = 2
) (
   input  logic             clk_top,
   input  logic             reset,
   input  logic             coin,
   input  logic             double_wash,
   input  logic [ER_W-1:0]  extra_rinse,
   input  logic             pause,
   input  logic             abort,
   output logic [2:0]       current_state,
   output logic             wash_done,
   output logic             busy,
   output logic [CNT_W-1:0] phase_remaining
);

   typedef enum logic [2:0] {
      StIdle     = 3'd0,
      StFilling  = 3'd1,
      StWashing  = 3'd2,
      StRinsing  = 3'd3,
      StSpinning = 3'd4,
      StDraining = 3'd5
   } state_e;

   localparam logic [CNT_W-1:0] FillT  = CNT_W'(FILL_TICKS);
   localparam logic [CNT_W-1:0] WashT  = CNT_W'(WASH_TICKS);
   localparam logic [CNT_W-1:0] RinseT = CNT_W'(RINSE_TICKS);
   localparam logic [CNT_W-1:0] SpinT  = CNT_W'(SPIN_TICKS);
   localparam logic [CNT_W-1:0] DrainT = CNT_W'(DRAIN_TICKS);

   state_e            state_q, state_d;
   logic [CNT_W-1:0]  timer_q, timer_d;
   logic              dw_q, dw_d;
   logic [ER_W-1:0]   er_q, er_d;
   logic              second_q, second_d;
   logic [ER_W-1:0]   rinse_cnt_q, rinse_cnt_d;
   logic              done_q, done_d;
   logic [CNT_W-1:0]  ticks_cur;
   logic              last_tick;

   always_ff @(posedge clk_top or negedge reset) begin
      if (!reset) begin
         state_q     <= StIdle;
         timer_q     <= '0;
         dw_q        <= 1'b0;
         er_q        <= '0;
         second_q    <= 1'b0;
         rinse_cnt_q <= '0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         timer_q     <= timer_d;
         dw_q        <= dw_d;
         er_q        <= er_d;
         second_q    <= second_d;
         rinse_cnt_q <= rinse_cnt_d;
         done_q      <= done_d;
      end
   end

   always_comb begin
      ticks_cur = '0;
      unique case (state_q)
         StFilling:  ticks_cur = FillT;
         StWashing:  ticks_cur = WashT;
         StRinsing:  ticks_cur = RinseT;
         StSpinning: ticks_cur = SpinT;
         StDraining: ticks_cur = DrainT;
         default:    ticks_cur = '0;
      endcase
   end

   assign last_tick = (timer_q == ticks_cur - CNT_W'(1));

   always_comb begin
      state_d     = state_q;
      timer_d     = timer_q;
      dw_d        = dw_q;
      er_d        = er_q;
      second_d    = second_q;
      rinse_cnt_d = rinse_cnt_q;
      done_d      = 1'b0;

      unique case (state_q)
         StIdle: begin
            timer_d = '0;
            if (coin && !abort) begin
               state_d     = StFilling;
               dw_d        = double_wash;
               er_d        = extra_rinse;
               second_d    = 1'b0;
               rinse_cnt_d = '0;
            end
         end
         StFilling, StWashing, StRinsing, StSpinning: begin
            // Abort outranks both pause and a coincident phase expiry.
            if (abort) begin
               state_d     = StDraining;
               timer_d     = '0;
               second_d    = 1'b0;
               rinse_cnt_d = '0;
            end else if (!pause) begin
               if (last_tick) begin
                  timer_d = '0;
                  unique case (state_q)
                     StFilling: state_d = StWashing;
                     StWashing: state_d = StRinsing;
                     StRinsing: begin
                        if (dw_q && !second_q) begin
                           state_d  = StWashing;
                           second_d = 1'b1;
                        end else if (rinse_cnt_q < er_q) begin
                           state_d     = StRinsing;
                           rinse_cnt_d = rinse_cnt_q + ER_W'(1);
                        end else begin
                           state_d = StSpinning;
                        end
                     end
                     default: begin
                        state_d = StIdle;
                        done_d  = 1'b1;
                     end
                  endcase
               end else begin
                  timer_d = timer_q + CNT_W'(1);
               end
            end
         end
         StDraining: begin
            if (last_tick) begin
               state_d = StIdle;
               timer_d = '0;
            end else begin
               timer_d = timer_q + CNT_W'(1);
            end
         end
         default: begin
            state_d = StIdle;
            timer_d = '0;
         end
      endcase
   end

   assign current_state   = state_q;
   assign busy            = (state_q != StIdle);
   assign wash_done       = done_q;
   assign phase_remaining = ticks_cur - timer_q;

endmodule
